clint_vec: RTL and testbench

// Parametrised core-local interrupt arbiter/sequencer. Accepts NUM_IRQ external sources plus ECALL/EBREAK/MRET

---
 rtl/clint_vec.sv | 130 +++++++++++++
 tb/tb_clint_vec.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/clint_vec.sv
// clint_vec: fixed-priority interrupt/exception sequencer that writes mepc/mstatus/mcause and redirects ex.
// Define CLINT_VECTORED_EN to vector async traps to base+4*cause when mtvec mode is 2'b01.
module clint_vec #(
    parameter int                 NUM_IRQ    = 4,
    parameter int                 XLEN       = 32,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK  = '0,
    parameter int                 CAUSE_BASE = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic [NUM_IRQ-1:0] irq_en_i,
    input  logic               global_int_en_i,
    input  logic [31:0]        inst_i,
    input  logic [XLEN-1:0]    inst_addr_i,
    input  logic               jump_flag_i,
    input  logic [XLEN-1:0]    jump_addr_i,
    input  logic               div_started_i,
    input  logic [XLEN-1:0]    csr_mtvec_i,
    input  logic [XLEN-1:0]    csr_mepc_i,
    input  logic [XLEN-1:0]    csr_mstatus_i,
    output logic               hold_flag_o,
    output logic               we_o,
    output logic [XLEN-1:0]    waddr_o,
    output logic [XLEN-1:0]    data_o,
    output logic               int_assert_o,
    output logic [XLEN-1:0]    int_addr_o,
    output logic [NUM_IRQ-1:0] irq_claim_o,
    output logic [NUM_IRQ-1:0] irq_pending_o
);
    localparam logic [31:0]     INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0]     INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0]     INST_MRET   = 32'h3020_0073;
    localparam logic [XLEN-1:0] CSR_MSTATUS = XLEN'(12'h300);
    localparam logic [XLEN-1:0] CSR_MEPC    = XLEN'(12'h341);
    localparam logic [XLEN-1:0] CSR_MCAUSE  = XLEN'(12'h342);

    typedef enum logic [2:0] {S_IDLE, S_MEPC, S_MSTATUS, S_MCAUSE, S_MRET} state_t;
    state_t r_state, w_next;

    logic [NUM_IRQ-1:0] r_pend, r_prev, r_claim, w_cand;
    logic [4:0]         w_idx;
    logic [XLEN-1:0]    r_cause, w_cause, w_epc, w_base, w_target, w_trap_mst, w_ret_mst;
    logic [XLEN-1:0]    r_waddr, r_data, r_int_addr;
    logic               r_we, r_int_assert;
    logic               w_sync, w_async, w_take_sync, w_take_async, w_take_mret;

    assign w_cand       = r_pend & irq_en_i;
    assign w_sync       = inst_i == INST_ECALL || inst_i == INST_EBREAK;
    assign w_async      = |w_cand && global_int_en_i;
    // a pending ECALL/EBREAK stalled by the divider blocks everything else
    assign w_take_sync  = w_sync && !div_started_i;
    assign w_take_async = !w_sync && w_async;
    assign w_take_mret  = !w_sync && !w_async && inst_i == INST_MRET;

    always_comb begin
        w_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) if (w_cand[i]) w_idx = 5'(i);
    end

    assign w_epc = w_sync ? (jump_flag_i ? jump_addr_i - XLEN'(4) : inst_addr_i)
                          : (jump_flag_i ? jump_addr_i : div_started_i ? inst_addr_i - XLEN'(4) : inst_addr_i);
    assign w_cause = w_sync ? XLEN'(inst_i == INST_ECALL ? 11 : 3)
                            : {1'b1, (XLEN-1)'(CAUSE_BASE + int'(w_idx))};

    always_comb begin
        w_trap_mst    = csr_mstatus_i;
        w_trap_mst[7] = csr_mstatus_i[3];
        w_trap_mst[3] = 1'b0;
        w_ret_mst     = csr_mstatus_i;
        w_ret_mst[3]  = csr_mstatus_i[7];
        w_ret_mst[7]  = 1'b1;
    end

    assign w_base = {csr_mtvec_i[XLEN-1:2], 2'b00};
`ifdef CLINT_VECTORED_EN
    assign w_target = (csr_mtvec_i[1:0] == 2'b01 && r_cause[XLEN-1]) ? w_base + {r_cause[XLEN-3:0], 2'b00} : w_base;
`else
    logic w_unused_mode;
    assign w_unused_mode = ^csr_mtvec_i[1:0];
    assign w_target      = w_base;
`endif

    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE:    w_next = (w_take_sync || w_take_async) ? S_MEPC : w_take_mret ? S_MRET : S_IDLE;
            S_MEPC:    w_next = S_MSTATUS;
            S_MSTATUS: w_next = S_MCAUSE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_pend       <= '0;
            r_prev       <= '0;
            r_claim      <= '0;
            r_cause      <= '0;
            r_we         <= 1'b0;
            r_waddr      <= '0;
            r_data       <= '0;
            r_int_assert <= 1'b0;
            r_int_addr   <= '0;
        end else begin
            r_state      <= w_next;
            r_prev       <= irq_i;
            r_pend       <= (EDGE_MASK & ((r_pend & ~r_claim) | (irq_i & ~r_prev))) | (~EDGE_MASK & irq_i);
            r_claim      <= (r_state == S_IDLE && w_take_async) ? NUM_IRQ'(1) << w_idx : '0;
            if (w_next == S_MEPC) r_cause <= w_cause;
            r_we         <= w_next != S_IDLE;
            r_waddr      <= w_next == S_MEPC ? CSR_MEPC : w_next == S_MCAUSE ? CSR_MCAUSE :
                            (w_next == S_MSTATUS || w_next == S_MRET) ? CSR_MSTATUS : '0;
            r_data       <= w_next == S_MEPC ? w_epc : w_next == S_MSTATUS ? w_trap_mst :
                            w_next == S_MCAUSE ? r_cause : w_next == S_MRET ? w_ret_mst : '0;
            r_int_assert <= w_next == S_MCAUSE || w_next == S_MRET;
            r_int_addr   <= w_next == S_MCAUSE ? w_target : w_next == S_MRET ? csr_mepc_i : '0;
        end
    end

    assign hold_flag_o   = (r_state != S_IDLE) | r_int_assert;
    assign we_o          = r_we;
    assign waddr_o       = r_waddr;
    assign data_o        = r_data;
    assign int_assert_o  = r_int_assert;
    assign int_addr_o    = r_int_addr;
    assign irq_claim_o   = r_claim;
    assign irq_pending_o = r_pend;
endmodule

// File: tb/tb_clint_vec.sv
// tb_clint_vec: directed scenarios plus randomized traffic checked every cycle against a sequence-queue model.
module tb_clint_vec;
    localparam int          N      = 4;
    localparam logic [N-1:0] EMASK = 4'b1001;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] MRET   = 32'h3020_0073;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic         clk_i = 1'b0, rst_i = 1'b1;
    logic [N-1:0] irq_i = '0, irq_en_i = '0;
    logic         global_int_en_i = 1'b0, jump_flag_i = 1'b0, div_started_i = 1'b0;
    logic [31:0]  inst_i = NOP, inst_addr_i = '0, jump_addr_i = '0;
    logic [31:0]  csr_mtvec_i = '0, csr_mepc_i = '0, csr_mstatus_i = '0;
    logic         hold_flag_o, we_o, int_assert_o;
    logic [31:0]  waddr_o, data_o, int_addr_o;
    logic [N-1:0] irq_claim_o, irq_pending_o;

    always #5 clk_i = ~clk_i;

    clint_vec #(.NUM_IRQ(N), .XLEN(32), .EDGE_MASK(EMASK), .CAUSE_BASE(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .irq_i(irq_i), .irq_en_i(irq_en_i),
        .global_int_en_i(global_int_en_i), .inst_i(inst_i), .inst_addr_i(inst_addr_i),
        .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i), .div_started_i(div_started_i),
        .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i), .csr_mstatus_i(csr_mstatus_i),
        .hold_flag_o(hold_flag_o), .we_o(we_o), .waddr_o(waddr_o), .data_o(data_o),
        .int_assert_o(int_assert_o), .int_addr_o(int_addr_o), .irq_claim_o(irq_claim_o),
        .irq_pending_o(irq_pending_o)
    );

    int n_cmp = 0, n_bad = 0;

    typedef enum int {K_NONE, K_MEPC, K_MST, K_MCAUSE, K_MRET} kind_t;
    kind_t        m_cur;
    kind_t        m_q[$];
    logic [N-1:0] m_pend, m_prev, e_claim;
    logic [31:0]  m_epc, m_cause, e_waddr, e_data, e_iaddr;
    logic         e_we, e_ia;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cur = K_NONE;
        m_q.delete();
        m_pend = '0; m_prev = '0; e_claim = '0;
        m_epc = '0; m_cause = '0;
        e_we = 1'b0; e_ia = 1'b0; e_waddr = '0; e_data = '0; e_iaddr = '0;
    endtask

    // Advances the model across the next clock edge using the inputs now being driven.
    task automatic model_step();
        logic [N-1:0] np, cand;
        logic [31:0]  mst, tgt;
        bit           is_sync;
        kind_t        nxt;
        int           idx;
        for (int i = 0; i < N; i++)
            np[i] = EMASK[i] ? ((m_pend[i] && !e_claim[i]) || (irq_i[i] && !m_prev[i])) : irq_i[i];
        m_prev  = irq_i;
        e_claim = '0;
        if (m_cur == K_NONE) begin
            is_sync = inst_i == ECALL || inst_i == EBREAK;
            cand    = m_pend & irq_en_i;
            if (is_sync) begin
                if (!div_started_i) begin
                    m_q     = '{K_MEPC, K_MST, K_MCAUSE};
                    m_epc   = jump_flag_i ? jump_addr_i - 32'd4 : inst_addr_i;
                    m_cause = inst_i == ECALL ? 32'd11 : 32'd3;
                end
            end else if (cand != 0 && global_int_en_i) begin
                idx = 0;
                while (!cand[idx]) idx++;
                m_q          = '{K_MEPC, K_MST, K_MCAUSE};
                m_epc        = jump_flag_i ? jump_addr_i : div_started_i ? inst_addr_i - 32'd4 : inst_addr_i;
                m_cause      = 32'h8000_0000 | 32'(16 + idx);
                e_claim[idx] = 1'b1;
            end else if (inst_i == MRET) m_q = '{K_MRET};
        end
        nxt = m_q.size() != 0 ? m_q.pop_front() : K_NONE;
        mst = csr_mstatus_i;
        tgt = csr_mtvec_i & ~32'd3;
`ifdef CLINT_VECTORED_EN
        if (csr_mtvec_i[1:0] == 2'b01 && m_cause[31]) tgt = tgt + 4 * (m_cause & 32'h7fff_ffff);
`endif
        e_we = nxt != K_NONE;
        e_ia = nxt == K_MCAUSE || nxt == K_MRET;
        case (nxt)
            K_MEPC:   begin e_waddr = 32'h341; e_data = m_epc; e_iaddr = 0; end
            K_MST:    begin e_waddr = 32'h300; e_data = (mst & ~32'h88) | (mst[3] ? 32'h80 : 32'h0); e_iaddr = 0; end
            K_MCAUSE: begin e_waddr = 32'h342; e_data = m_cause; e_iaddr = tgt; end
            K_MRET:   begin e_waddr = 32'h300; e_data = (mst & ~32'h8) | 32'h80 | (mst[7] ? 32'h8 : 32'h0); e_iaddr = csr_mepc_i; end
            default:  begin e_waddr = 0; e_data = 0; e_iaddr = 0; end
        endcase
        m_cur  = nxt;
        m_pend = np;
    endtask

    task automatic compare_all();
        chk("we", 32'(we_o), 32'(e_we));
        chk("waddr", waddr_o, e_waddr);
        chk("data", data_o, e_data);
        chk("int_assert", 32'(int_assert_o), 32'(e_ia));
        chk("int_addr", int_addr_o, e_iaddr);
        chk("claim", 32'(irq_claim_o), 32'(e_claim));
        chk("pending", 32'(irq_pending_o), 32'(m_pend));
        chk("hold", 32'(hold_flag_o), 32'(m_cur != K_NONE));
    endtask

    task automatic step();
        model_step();
        @(posedge clk_i);
        @(negedge clk_i);
        compare_all();
    endtask

    task automatic rand_inputs();
        int r;
        r = $urandom_range(0, 99);
        inst_i = r < 8 ? ECALL : r < 16 ? EBREAK : r < 26 ? MRET : 32'($urandom);
        for (int i = 0; i < N; i++) if ($urandom_range(0, 7) == 0) irq_i[i] = ~irq_i[i];
        if ($urandom_range(0, 15) == 0) irq_en_i = N'($urandom);
        global_int_en_i = $urandom_range(0, 3) != 0;
        jump_flag_i     = $urandom_range(0, 3) == 0;
        jump_addr_i     = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 3)) : 32'($urandom);
        inst_addr_i     = 32'($urandom);
        div_started_i   = $urandom_range(0, 3) == 0;
        csr_mtvec_i     = 32'($urandom);
        csr_mepc_i      = 32'($urandom);
        csr_mstatus_i   = 32'($urandom);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk_i);
        compare_all();
        rst_i = 1'b0;

        csr_mtvec_i = 32'h2000; csr_mstatus_i = 32'h8; inst_i = ECALL; inst_addr_i = 32'h100;
        step(); chk("ecall_mepc", data_o, 32'h100); chk("ecall_mepc_addr", waddr_o, 32'h341);
        inst_i = NOP;
        step(); chk("ecall_mstatus", data_o, 32'h80);
        step(); chk("ecall_mcause", data_o, 32'd11); chk("ecall_target", int_addr_o, 32'h2000);
        chk("ecall_redirect", 32'(int_assert_o), 32'd1);
        step(); chk("ecall_done", 32'(hold_flag_o), 32'd0);

        irq_en_i = 4'hF; global_int_en_i = 1'b1; irq_i = 4'b0110; inst_addr_i = 32'h200;
        step();
        step(); chk("lvl_claim", 32'(irq_claim_o), 32'h2);
        irq_i = '0;
        step(); step(); chk("lvl_mcause", data_o, 32'h8000_0011);
        step(); step(); chk("lvl_single_trap", 32'(we_o), 32'd0);

        inst_i = ECALL;
        step();
        inst_i = NOP; irq_i = 4'b0001;
        step();
        irq_i = '0;
        step(); step(); chk("edge_held", 32'(irq_pending_o), 32'h1);
        step(); chk("edge_claim", 32'(irq_claim_o), 32'h1); chk("edge_retrap", waddr_o, 32'h341);
        step(); step(); step();

        inst_i = ECALL; div_started_i = 1'b1;
        repeat (3) begin step(); chk("div_defer", 32'(we_o), 32'd0); end
        div_started_i = 1'b0;
        step(); chk("div_release", 32'(we_o), 32'd1);
        inst_i = NOP;
        step(); step(); step();

        inst_i = MRET; csr_mstatus_i = 32'h80; csr_mepc_i = 32'h1234;
        step(); chk("mret_addr", int_addr_o, 32'h1234); chk("mret_mstatus", data_o, 32'h88);
        inst_i = NOP;
        step(); chk("mret_done", 32'(hold_flag_o), 32'd0);

        csr_mtvec_i = 32'h1001; irq_i = 4'b0010; csr_mstatus_i = 32'h8;
        step(); step();
        irq_i = '0;
        step(); step();
`ifdef CLINT_VECTORED_EN
        chk("vec_target", int_addr_o, 32'h1044);
`else
        chk("vec_target", int_addr_o, 32'h1000);
`endif
        step();

        csr_mtvec_i = 32'h2000; inst_i = ECALL;
        step();
        inst_i = NOP;
        step(); chk("pre_rst_mstatus", waddr_o, 32'h300);
        #2 rst_i = 1'b1;
        #1 model_reset();
        compare_all();
        chk("rst_we", 32'(we_o), 32'd0);
        #1 rst_i = 1'b0;
        step(); chk("rst_no_mcause", 32'(we_o), 32'd0);
        step();

        repeat (3000) begin
            rand_inputs();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
